// File: rtl/dbg_frame_latch.sv
// Debug frame latch: samples SEQ_NUM debug values once per VGA frame and publishes them atomically.
// Optional `DBG_FRAME_CNT_EN adds a 16-bit frame_cnt output counting commits.
module dbg_frame_latch #(
   parameter int unsigned SEQ_LEN      = 16,
   parameter int unsigned SEQ_NUM      = 16,
   parameter int unsigned SCREEN_WIDTH = 10,
   parameter int unsigned V_TRIG       = 480
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    p_tick,
   input  logic [9:0]              x,
   input  logic [9:0]              y,
   input  logic                    freeze,
   input  logic [SCREEN_WIDTH-1:0] char_x_in,
   input  logic [SCREEN_WIDTH-1:0] char_y_in,
   output logic [3:0]              src_sel,
   input  logic [SEQ_LEN-1:0]      src_data,
   input  logic [3:0]              rd_idx,
   output logic [SEQ_LEN-1:0]      rd_data,
   output logic [SCREEN_WIDTH-1:0] char_x,
   output logic [SCREEN_WIDTH-1:0] char_y,
   output logic                    busy,
   output logic                    snap_valid,
   output logic                    commit
`ifdef DBG_FRAME_CNT_EN
   ,
   output logic [15:0]             frame_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

   localparam logic [3:0] LAST_SEL = 4'(SEQ_NUM - 1);
   localparam logic [4:0] NUM5     = 5'(SEQ_NUM);

   state_t                    state;
   logic [SEQ_LEN-1:0]        shadow [SEQ_NUM];
   logic [SEQ_LEN-1:0]        bank   [SEQ_NUM];
   logic [SCREEN_WIDTH-1:0]   shadow_x;
   logic [SCREEN_WIDTH-1:0]   shadow_y;
   logic                      trig;
   logic                      rd_ok;

   always_comb begin
      trig  = p_tick && (x == '0) && (y == 10'(V_TRIG));
      rd_ok = ({1'b0, rd_idx} < NUM5);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         src_sel    <= '0;
         busy       <= 1'b0;
         commit     <= 1'b0;
         snap_valid <= 1'b0;
         shadow_x   <= '0;
         shadow_y   <= '0;
         char_x     <= '0;
         char_y     <= '0;
         rd_data    <= '0;
         for (int unsigned i = 0; i < SEQ_NUM; i++) begin
            shadow[i] <= '0;
            bank[i]   <= '0;
         end
`ifdef DBG_FRAME_CNT_EN
         frame_cnt  <= '0;
`endif
      end else begin
         commit <= 1'b0;
         case (state)
            IDLE: begin
               if (trig && !freeze) begin
                  state    <= CAPTURE;
                  busy     <= 1'b1;
                  src_sel  <= '0;
                  shadow_x <= char_x_in;
                  shadow_y <= char_y_in;
               end
            end
            CAPTURE: begin
               shadow[src_sel] <= src_data;
               if (src_sel == LAST_SEL) begin
                  state   <= COMMIT;
                  busy    <= 1'b0;
                  commit  <= 1'b1;
                  src_sel <= '0;
               end else begin
                  src_sel <= src_sel + 4'd1;
               end
            end
            COMMIT: begin
               state      <= IDLE;
               snap_valid <= 1'b1;
               char_x     <= shadow_x;
               char_y     <= shadow_y;
               for (int unsigned i = 0; i < SEQ_NUM; i++) begin
                  bank[i] <= shadow[i];
               end
`ifdef DBG_FRAME_CNT_EN
               frame_cnt  <= frame_cnt + 16'd1;
`endif
            end
            default: state <= IDLE;
         endcase

         // A read issued on the commit edge bypasses to the shadow so it returns the new frame.
         if (!rd_ok) begin
            rd_data <= '0;
         end else if (state == COMMIT) begin
            rd_data <= shadow[rd_idx];
         end else begin
            rd_data <= bank[rd_idx];
         end
      end
   end

endmodule

// File: doc/dbg_frame_latch.md
DBG_FRAME_LATCH -- requirements
Module: dbg_frame_latch

Interface
REQ-001 Parameters SHALL be:
- SEQ_LEN, 16, width of each debug value.
- SEQ_NUM, 16, number of debug values; SHALL be at most 16.
- SCREEN_WIDTH, 10, width of character position.
- V_TRIG, 480, VGA line on which capture starts.
REQ-002 Ports SHALL be:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- p_tick  in  1  pixel tick from the VGA controller.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- freeze  in  1  1 = skip new captures and hold the current snapshot.
- char_x_in  in  SCREEN_WIDTH  live character X.
- char_y_in  in  SCREEN_WIDTH  live character Y.
- src_sel  out  4  index of the debug value being sampled; drives an external combinational mux.
- src_data  in  SEQ_LEN  mux output for src_sel, valid in the same cycle.
- rd_idx  in  4  readout index from pixel_gen.
- rd_data  out  SEQ_LEN  snapshot value for rd_idx.
- char_x  out  SCREEN_WIDTH  snapshot X.
- char_y  out  SCREEN_WIDTH  snapshot Y.
- busy  out  1  1 while state is CAPTURE.
- snap_valid  out  1  1 after the first commit.
- commit  out  1  one-cycle pulse on each commit.
REQ-003 Reset SHALL be asynchronous and active-low on sys_rst_n, and sys_clk SHALL be the only clock.

Function
REQ-004 Trigger SHALL be true when p_tick=1, x=0 and y=V_TRIG are all present in the same sys_clk cycle.
REQ-005 The state machine SHALL have three states, with IDLE as the reset state:
- IDLE: on trigger with freeze=0, go to CAPTURE.
- CAPTURE: stay for exactly SEQ_NUM cycles, then go to COMMIT.
- COMMIT: stay one cycle, then go to IDLE.
REQ-006 On the IDLE-to-CAPTURE clock edge, the block SHALL register char_x_in and char_y_in into shadow registers and set src_sel to 0.
REQ-007 In CAPTURE cycle k (k = 0 to SEQ_NUM-1), src_sel SHALL equal k, src_data SHALL be written into shadow[k], and src_sel SHALL increment.
REQ-008 src_sel SHALL be 0 whenever the state is not CAPTURE.
REQ-009 In COMMIT, the block SHALL copy all shadow values and shadow positions into the output bank in one edge, so the output bank changes atomically and never shows a partial frame.
REQ-010 In COMMIT, commit SHALL be 1 for exactly one cycle, and snap_valid SHALL be set and then stay 1 until reset.
REQ-011 A trigger in CAPTURE or COMMIT SHALL be ignored, with no restart and no queuing.
REQ-012 When freeze=1 at a trigger, the block SHALL stay in IDLE and the output bank SHALL be unchanged.
REQ-013 freeze going high during CAPTURE SHALL NOT abort the capture; that capture SHALL still commit.
REQ-014 rd_data SHALL be registered, equal to the output bank at rd_idx, with 1-cycle latency.
REQ-015 rd_data SHALL be 0 when rd_idx is SEQ_NUM or greater.
REQ-016 If rd_idx reads during a COMMIT edge, the block SHALL return the new value one cycle after that edge.
REQ-017 All arithmetic SHALL be unsigned, and the 4-bit src_sel counter SHALL NOT wrap within CAPTURE.

Reset
REQ-018 Asserting reset SHALL immediately set state=IDLE and clear src_sel, rd_data, char_x, char_y, busy, snap_valid, commit, all shadow values and all output bank values to 0.
REQ-019 Reset asserted mid-CAPTURE SHALL discard the partial shadow data.
REQ-020 After reset release, the first capture SHALL wait for the next trigger.

Configuration
REQ-021 With DBG_FRAME_CNT_EN defined, the block SHALL add output frame_cnt [15:0], reset to 0.
REQ-022 With DBG_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 on each commit, wrap from 0xFFFF to 0x0000, and not change on frozen triggers.
REQ-023 Without DBG_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Basic capture: drive src_data = 0x1000+src_sel and char_x_in=123, then trigger. Required: busy=1 for 16 cycles, then commit pulses once. rd_idx=5 then returns 0x1005 after 1 cycle, and char_x=123.
- Atomic update: hold rd_idx=3 throughout a capture. Required: rd_data keeps the old value until the cycle after commit and never shows an intermediate value.
- Retrigger: assert a trigger again at CAPTURE cycle 7. Required: the capture length is still 16 cycles with only one commit, and frame_cnt rises by 1 when DBG_FRAME_CNT_EN is defined.
- Freeze: set freeze=1 at the trigger, with src_data changed. Required: no busy, no commit, and rd_data unchanged. Then raise freeze mid-CAPTURE. Required: that capture still commits.
- Mid-capture reset: assert sys_rst_n=0 at CAPTURE cycle 10. Required: all outputs 0 and snap_valid=0. After release and the next trigger, a full new snapshot appears.
- Out-of-range read and counter wrap: rd_idx=15 with SEQ_NUM=12 returns 0. With DBG_FRAME_CNT_EN defined, 65536 commits take frame_cnt from 0xFFFF back to 0x0000.
